xbar_rr_arbiter: RTL and testbench
==================================

# xbar_rr_arbiter

Parametrised round-robin arbiter for the crossbar: selects one of `NUM_REQ` requesters for a single downstream peripheral port and locks the grant until the peripheral completes (`p_ready_i`). It replaces the fixed three-way rotating selector. It adds true round-robin fairness, where priority moves past the last winner, and an optional hold-timeout that force-releases a stalled grant.

## Interface
- `NUM_REQ`, default 3: number of requesters. Legal values are ≥ 2.
- `TIMEOUT_CYCLES`, default 0: maximum number of grant cycles without `p_ready_i`. 0 disables the timeout. Otherwise it must be ≥ 2.
- Derived: `IDX_W = $clog2(NUM_REQ)`. The hold counter is `$clog2(TIMEOUT_CYCLES+1)` bits, with a minimum of 1.
- `clk_i` input, 1 bit: clock.
- `rst_ni` input, 1 bit: reset, asynchronous, active-low.
- `req_i` input, `NUM_REQ` bits: pending request per requester.
- `p_ready_i` input, 1 bit: the peripheral completes the granted transaction this cycle.
- `gnt_o` output, `NUM_REQ` bits: one-hot grant, or all-zero.
- `gnt_idx_o` output, `IDX_W` bits: binary index of the granted requester. It is 0 when there is no grant.
- `gnt_valid_o` output, 1 bit: equals `|gnt_o`.
- `busy_o` output, 1 bit: the FSM is in ACTIVE (grant locked).
- `timeout_o` output, 1 bit: single-cycle pulse, the grant is being force-released.

## Operation
- State: FSM {IDLE, ACTIVE}, priority pointer `ptr_q` (`IDX_W` bits, range 0..NUM_REQ-1), locked index `lock_q`, hold counter `cnt_q`.
- Arbitration (combinational): scan `req_i` starting at `ptr_q` and incrementing modulo `NUM_REQ`. The first set bit wins. If no bit is set, there is no winner.
- IDLE:
  - `gnt_o` is the one-hot of the winner, presented in the same cycle.
  - No winner: all state holds. The pointer does NOT rotate on idle cycles.
  - Winner and `p_ready_i=1`: the transaction completes in 1 cycle. `ptr_q <= (winner+1) mod NUM_REQ`. Stay in IDLE.
  - Winner and `p_ready_i=0`: `lock_q <= winner`, `cnt_q <= 1`, go to ACTIVE.
- ACTIVE:
  - `gnt_o` is the one-hot of `lock_q`, regardless of `req_i`. A deasserted or changed request does not move the grant.
  - `p_ready_i=1`: `ptr_q <= (lock_q+1) mod NUM_REQ`, go to IDLE.
  - Timeout condition: `TIMEOUT_CYCLES != 0`, `p_ready_i=0`, and `cnt_q+1 == TIMEOUT_CYCLES`. Then `timeout_o=1` in this cycle, `ptr_q <= (lock_q+1) mod NUM_REQ`, go to IDLE.
  - Otherwise: `cnt_q <= cnt_q+1`, stay in ACTIVE. The counter saturates and does not wrap. It is unused when `TIMEOUT_CYCLES=0`.
- Wrap-around: the pointer increments from `NUM_REQ-1` to 0. This covers non-power-of-2 `NUM_REQ`.
- `p_ready_i` while there is no grant (IDLE, no winner) is ignored.
- `p_ready_i` and the timeout limit in the same cycle: completion wins and `timeout_o` stays 0.

## Timing
- Reset values: FSM=IDLE, `ptr_q=0`, `lock_q=0`, `cnt_q=0`, `busy_o=0`, `timeout_o=0`. `gnt_o`, `gnt_idx_o` and `gnt_valid_o` follow `req_i` combinationally with `ptr_q=0`, so they are 0 when `req_i=0`.
- Request-to-grant latency is 0 cycles in IDLE, combinational from `req_i`. There is no combinational path from `req_i` in ACTIVE.
- Back-to-back: with `p_ready_i` held high, a new grant is possible every cycle.
- After an ACTIVE completion, the next arbitration happens in the following cycle (IDLE).
- Max grant length is `TIMEOUT_CYCLES` cycles, including the IDLE grant cycle. `timeout_o` is combinational and coincides with the last grant cycle.
- Reset asserted mid-ACTIVE: the grant drops immediately (asynchronously), and `busy_o` and `timeout_o` go to 0.
- Fairness: with all requesters continuously requesting, each is granted at least once in every `NUM_REQ` consecutive grants.

## Test plan
- Reset with `req_i=0`: `gnt_o=000`, `gnt_valid_o=0`, `busy_o=0`, `timeout_o=0`. Release reset and hold `req_i=0` for 5 cycles: outputs unchanged and `ptr_q` stays 0.
- `NUM_REQ=3`, `req_i=111`, `p_ready_i=1` every cycle: `gnt_o` cycles through 001, 010, 100, 001 on consecutive cycles, and `gnt_idx_o` reads 0, 1, 2, 0.
- `req_i=110` from reset with `p_ready_i=0` for 2 cycles, `req_i` switched to 100 in cycle 2, then `p_ready_i=1`: `gnt_o=010` held for 3 cycles, `busy_o=1` for cycles 2–3. The next cycle grants `gnt_o=100`.
- `TIMEOUT_CYCLES=4`, `req_i=001`, `p_ready_i=0` throughout: `gnt_o=001` for 4 cycles with `timeout_o=1` in the 4th only. Cycle 5 is IDLE and re-grants 001 via wrap from `ptr=1`. Variant: `p_ready_i=1` in the 4th cycle gives `timeout_o=0`.
- Assert reset in the 2nd ACTIVE cycle (`lock=2`) with `req_i=011`: `gnt_o` immediately becomes 001 (`ptr=0`) and `busy_o=0`.
- `NUM_REQ=5`, `TIMEOUT_CYCLES=0`, all requesting, random `p_ready_i` for 1000 cycles: `gnt_o` is always one-hot, the order is 0, 1, 2, 3, 4, 0, …, and no grant changes while `busy_o=1`.

Source files
------------

// File: rtl/xbar_rr_arbiter.sv
// Round-robin arbiter for one crossbar peripheral port. The grant is locked until
// p_ready_i, or until an optional hold timeout force-releases it.
module xbar_rr_arbiter #(
  parameter  int NUM_REQ        = 3,
  parameter  int TIMEOUT_CYCLES = 0,
  localparam int IDX_W          = $clog2(NUM_REQ),
  localparam int CNT_W          = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               p_ready_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_valid_o,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_ACTIVE = 1'b1;

  logic             state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] lock_q, lock_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             to_hit;

  function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // Scan requests from ptr_q upward, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum  = {1'b0, ptr_q} + (IDX_W+1)'(i);
      cand = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                          : IDX_W'(sum);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign to_hit = (TIMEOUT_CYCLES != 0) && !p_ready_i &&
                  ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    cnt_d     = cnt_q;
    timeout_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          if (p_ready_i) begin
            ptr_d = nxt(win_idx);
          end else begin
            state_d = ST_ACTIVE;
            lock_d  = win_idx;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      default: begin
        if (p_ready_i) begin
          ptr_d   = nxt(lock_q);
          state_d = ST_IDLE;
        end else if (to_hit) begin
          timeout_o = 1'b1;
          ptr_d     = nxt(lock_q);
          state_d   = ST_IDLE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
    end
  end

  // While locked the grant comes only from lock_q, never from req_i.
  assign busy_o      = (state_q == ST_ACTIVE);
  assign gnt_valid_o = busy_o | win_found;
  assign gnt_idx_o   = busy_o ? lock_q : (win_found ? win_idx : '0);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gnt
    assign gnt_o[g] = gnt_valid_o && (gnt_idx_o == IDX_W'(g));
  end

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Directed bench for xbar_rr_arbiter: table vectors on a 3-way instance, hand
// sequences for locking/timeout/reset, and a 5-way fairness run against a model.
module tb_xbar_rr_arbiter;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // A: NUM_REQ=3, no timeout
  logic [2:0] req_a, gnt_a;
  logic [1:0] idx_a;
  logic       pr_a, val_a, busy_a, to_a;
  // B: NUM_REQ=3, TIMEOUT_CYCLES=4
  logic [2:0] req_b, gnt_b;
  logic [1:0] idx_b;
  logic       pr_b, val_b, busy_b, to_b;
  // C: NUM_REQ=5, no timeout
  logic [4:0] req_c, gnt_c;
  logic [2:0] idx_c;
  logic       pr_c, val_c, busy_c, to_c;

  xbar_rr_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(0)) u_a (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_a), .p_ready_i(pr_a), .gnt_o(gnt_a),
    .gnt_idx_o(idx_a), .gnt_valid_o(val_a), .busy_o(busy_a), .timeout_o(to_a));
  xbar_rr_arbiter #(.NUM_REQ(3), .TIMEOUT_CYCLES(4)) u_b (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_b), .p_ready_i(pr_b), .gnt_o(gnt_b),
    .gnt_idx_o(idx_b), .gnt_valid_o(val_b), .busy_o(busy_b), .timeout_o(to_b));
  xbar_rr_arbiter #(.NUM_REQ(5), .TIMEOUT_CYCLES(0)) u_c (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_c), .p_ready_i(pr_c), .gnt_o(gnt_c),
    .gnt_idx_o(idx_c), .gnt_valid_o(val_c), .busy_o(busy_c), .timeout_o(to_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Packed view {gnt, idx, valid, busy, timeout}
  function automatic logic [7:0] pk(input logic [2:0] g, input logic [1:0] i,
                                    input logic b, input logic t);
    return {g, i, |g, b, t};
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    req_a = '0; pr_a = 1'b0;
    req_b = '0; pr_b = 1'b0;
    req_c = '0; pr_c = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       pr;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[24];

  initial begin
    int m_next, m_lock, m_idx;
    logic m_busy;

    // idle, then back-to-back rotation, lock, wrap and long hold
    for (int i = 0; i < 5; i++) vt[i] = '{3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0)};
    vt[5]  = '{3'b111, 1'b1, pk(3'b001, 2'd0, 0, 0)};
    vt[6]  = '{3'b111, 1'b1, pk(3'b010, 2'd1, 0, 0)};
    vt[7]  = '{3'b111, 1'b1, pk(3'b100, 2'd2, 0, 0)};
    vt[8]  = '{3'b111, 1'b1, pk(3'b001, 2'd0, 0, 0)};
    vt[9]  = '{3'b000, 1'b1, pk(3'b000, 2'd0, 0, 0)};
    vt[10] = '{3'b101, 1'b0, pk(3'b100, 2'd2, 0, 0)};
    vt[11] = '{3'b000, 1'b0, pk(3'b100, 2'd2, 1, 0)};
    vt[12] = '{3'b011, 1'b1, pk(3'b100, 2'd2, 1, 0)};
    vt[13] = '{3'b011, 1'b1, pk(3'b001, 2'd0, 0, 0)};
    vt[14] = '{3'b011, 1'b1, pk(3'b010, 2'd1, 0, 0)};
    vt[15] = '{3'b001, 1'b1, pk(3'b001, 2'd0, 0, 0)};
    vt[16] = '{3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0)};
    vt[17] = '{3'b010, 1'b0, pk(3'b010, 2'd1, 0, 0)};
    for (int i = 18; i < 22; i++) vt[i] = '{3'b000, 1'b0, pk(3'b010, 2'd1, 1, 0)};
    vt[22] = '{3'b000, 1'b1, pk(3'b010, 2'd1, 1, 0)};
    vt[23] = '{3'b000, 1'b0, pk(3'b000, 2'd0, 0, 0)};

    // reset state
    rst_ni = 1'b0;
    req_a = '0; pr_a = 1'b0; req_b = '0; pr_b = 1'b0; req_c = '0; pr_c = 1'b0;
    #2;
    chk("reset_a", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b000, 2'd0, 0, 0));
    chk("reset_b", {gnt_b, idx_b, val_b, busy_b, to_b}, pk(3'b000, 2'd0, 0, 0));
    do_reset();

    for (int i = 0; i < 24; i++) begin
      req_a = vt[i].req;
      pr_a  = vt[i].pr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {gnt_a, idx_a, val_a, busy_a, to_a}, vt[i].exp);
      next_cycle();
    end

    // lock holds through a request change
    do_reset();
    req_a = 3'b110; pr_a = 1'b0;
    @(negedge clk); chk("lock_c1", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b010, 2'd1, 0, 0));
    next_cycle(); req_a = 3'b100;
    @(negedge clk); chk("lock_c2", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b010, 2'd1, 1, 0));
    next_cycle(); pr_a = 1'b1;
    @(negedge clk); chk("lock_c3", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b010, 2'd1, 1, 0));
    next_cycle();
    @(negedge clk); chk("lock_c4", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b100, 2'd2, 0, 0));
    next_cycle();

    // async reset in the 2nd ACTIVE cycle with lock=2
    do_reset();
    req_a = 3'b100; pr_a = 1'b0;
    @(negedge clk); chk("rst_idle", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b100, 2'd2, 0, 0));
    next_cycle(); req_a = 3'b011;
    @(negedge clk); chk("rst_act1", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b100, 2'd2, 1, 0));
    next_cycle();
    chk("rst_act2", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b100, 2'd2, 1, 0));
    #2 rst_ni = 1'b0;
    #1 chk("rst_drop", {gnt_a, idx_a, val_a, busy_a, to_a}, pk(3'b001, 2'd0, 0, 0));

    // timeout after 4 grant cycles, then completion on the 4th cycle beats it
    do_reset();
    req_b = 3'b001;
    for (int c = 1; c <= 9; c++) begin
      logic eb, et;
      pr_b = (c == 8);
      eb = (c == 2) || (c == 3) || (c == 4) || (c == 6) || (c == 7) || (c == 8);
      et = (c == 4);
      @(negedge clk);
      chk($sformatf("tmo_c%0d", c), {gnt_b, idx_b, val_b, busy_b, to_b}, pk(3'b001, 2'd0, eb, et));
      next_cycle();
    end

    // 5-way fairness with random completion
    do_reset();
    req_c = 5'b11111;
    m_next = 0; m_lock = 0; m_busy = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      pr_c = 1'($urandom_range(0, 1));
      m_idx = m_busy ? m_lock : m_next;
      @(negedge clk);
      chk($sformatf("fair_c%0d", c), {to_c, busy_c, val_c, idx_c, gnt_c},
          {1'b0, m_busy, 1'b1, 3'(m_idx), 5'(1 << m_idx)});
      if (!m_busy) begin
        if (pr_c) m_next = (m_next + 1) % 5;
        else begin m_busy = 1'b1; m_lock = m_next; end
      end else if (pr_c) begin
        m_busy = 1'b0;
        m_next = (m_lock + 1) % 5;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
